// File: rtl/pdm_capture_decimator.sv
// PDM microphone front end: mic-clock generation, one/two-channel capture and boxcar decimation
// into a valid/ready holding register. Define PDM_DC_BLOCK_EN to add a one-pole DC blocker.
module pdm_capture_decimator #(
  parameter int unsigned CLK_DIV  = 32,
  parameter int unsigned DECIM    = 256,
  parameter int unsigned OUT_W    = 16,
  parameter int unsigned CHANNELS = 1,
  parameter int unsigned DC_SHIFT = 8
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      enable_in,
  input  logic                      mic_data_in,
  output logic                      mic_clk_out,
  output logic                      pdm_tick_out,
  output logic [CHANNELS*OUT_W-1:0] sample_out,
  output logic                      sample_valid_out,
  input  logic                      sample_ready_in,
  output logic                      overrun_out
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned CNT_W = $clog2(DECIM);
  localparam int unsigned A     = CNT_W + 1;
  localparam int unsigned WW    = A + OUT_W;
  localparam int unsigned SHL   = (A <= OUT_W) ? OUT_W - A : 0;
  localparam int unsigned SHR   = (A > OUT_W) ? A - OUT_W : 0;

  if (CLK_DIV < 4 || CLK_DIV % 2 != 0 || DECIM < 4 || DECIM > 4096 ||
      (DECIM & (DECIM - 1)) != 0 || OUT_W < 8 || OUT_W > 24 ||
      CHANNELS < 1 || CHANNELS > 2 || DC_SHIFT < 1 || DC_SHIFT > 12) begin : g_param_err
    $error("pdm_capture_decimator: illegal parameter set");
  end

  logic [DIV_W-1:0]          div_q, div_d;
  logic                      mic_clk_q, mic_clk_d;
  logic                      tick_q, tick_d;
  logic                      bit_q, bit_d;
  logic                      cap0_q, cap0_d;
  logic                      cap1_q, cap1_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [A-1:0]              tally_q [CHANNELS];
  logic [A-1:0]              tally_d [CHANNELS];
  logic [CHANNELS*OUT_W-1:0] sample_q, sample_d;
  logic                      valid_q, valid_d;
  logic                      overrun_q, overrun_d;
  logic                      last_cap_c;
  logic                      frame_c;
  logic [CHANNELS*OUT_W-1:0] scaled_c;
  logic                      load_c;
  logic [CHANNELS*OUT_W-1:0] new_c;

  // Centre the ones-tally on zero, saturate to A signed bits, then scale to OUT_W.
  function automatic logic [OUT_W-1:0] scale(input logic [A-1:0] t);
    logic [A-1:0]         v;
    logic signed [WW-1:0] e;
    v = (t == A'(DECIM)) ? A'(DECIM / 2 - 1) : t - A'(DECIM / 2);
    e = WW'(signed'(v));
    e = (e <<< SHL) >>> SHR;
    return OUT_W'(e);
  endfunction

  // Divider, capture strobes (bit registered one cycle before it is tallied) and frame tally.
  always_comb begin : capture_comb
    div_d      = div_q;
    mic_clk_d  = 1'b0;
    tick_d     = 1'b0;
    bit_d      = 1'b0;
    cap0_d     = 1'b0;
    cap1_d     = 1'b0;
    cnt_d      = cnt_q;
    tally_d    = tally_q;
    last_cap_c = 1'b0;
    frame_c    = 1'b0;
    scaled_c   = '0;
    if (!enable_in) begin
      div_d = '0;
      cnt_d = '0;
      for (int c = 0; c < int'(CHANNELS); c++) tally_d[c] = '0;
    end else begin
      div_d     = (div_q == DIV_W'(CLK_DIV - 1)) ? '0 : div_q + 1'b1;
      mic_clk_d = (div_d < DIV_W'(CLK_DIV / 2));
      tick_d    = (div_d == '0);
      bit_d     = mic_data_in;
      cap0_d    = (div_q == DIV_W'(CLK_DIV / 2 - 1));
      cap1_d    = (CHANNELS == 2) && (div_q == DIV_W'(CLK_DIV - 1));
      last_cap_c = (CHANNELS == 2) ? cap1_q : cap0_q;
      for (int c = 0; c < int'(CHANNELS); c++) begin
        if ((c == 0) ? cap0_q : cap1_q) tally_d[c] = tally_q[c] + A'(bit_q);
      end
      if (last_cap_c) begin
        if (cnt_q == CNT_W'(DECIM - 1)) begin
          cnt_d   = '0;
          frame_c = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      if (frame_c) begin
        for (int c = 0; c < int'(CHANNELS); c++) begin
          scaled_c[c*OUT_W +: OUT_W] = scale(tally_d[c]);
          tally_d[c] = '0;
        end
      end
    end
  end

`ifdef PDM_DC_BLOCK_EN
  localparam int unsigned SW = OUT_W + DC_SHIFT + 2;
  localparam logic signed [SW-1:0] Y_MAX = SW'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [SW-1:0] Y_MIN = SW'(-(2 ** (OUT_W - 1)));

  logic signed [SW-1:0] y_q [CHANNELS];
  logic signed [SW-1:0] y_d [CHANNELS];
  logic [OUT_W-1:0]     xprev_q [CHANNELS];
  logic [OUT_W-1:0]     xprev_d [CHANNELS];
  logic                 dc_vld_q, dc_vld_d;

  function automatic logic [OUT_W-1:0] sat(input logic signed [SW-1:0] y);
    if (y > Y_MAX) return {1'b0, {(OUT_W - 1){1'b1}}};
    if (y < Y_MIN) return {1'b1, {(OUT_W - 1){1'b0}}};
    return OUT_W'(y);
  endfunction

  // y = x - x_prev + y_prev - (y_prev >>> DC_SHIFT), one cycle behind the frame end.
  always_comb begin : dc_comb
    y_d      = y_q;
    xprev_d  = xprev_q;
    dc_vld_d = frame_c;
    load_c   = dc_vld_q;
    new_c    = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      if (frame_c) begin
        y_d[c] = SW'(signed'(scaled_c[c*OUT_W +: OUT_W])) - SW'(signed'(xprev_q[c]))
               + y_q[c] - (y_q[c] >>> DC_SHIFT);
        xprev_d[c] = scaled_c[c*OUT_W +: OUT_W];
      end
      new_c[c*OUT_W +: OUT_W] = sat(y_q[c]);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin : dc_regs
    if (rst_in) begin
      dc_vld_q <= 1'b0;
      for (int c = 0; c < int'(CHANNELS); c++) begin
        y_q[c]     <= '0;
        xprev_q[c] <= '0;
      end
    end else begin
      dc_vld_q <= dc_vld_d;
      y_q      <= y_d;
      xprev_q  <= xprev_d;
    end
  end
`else
  assign load_c = frame_c;
  assign new_c  = scaled_c;
`endif

  // Holding register: a load always wins; overwriting an unaccepted frame flags overrun.
  always_comb begin : out_comb
    sample_d  = sample_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (load_c) begin
      sample_d = new_c;
      valid_d  = 1'b1;
      if (valid_q && !sample_ready_in) overrun_d = 1'b1;
    end else if (valid_q && sample_ready_in) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin : regs
    if (rst_in) begin
      div_q     <= '0;
      mic_clk_q <= 1'b0;
      tick_q    <= 1'b0;
      bit_q     <= 1'b0;
      cap0_q    <= 1'b0;
      cap1_q    <= 1'b0;
      cnt_q     <= '0;
      for (int c = 0; c < int'(CHANNELS); c++) tally_q[c] <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      mic_clk_q <= mic_clk_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      cap0_q    <= cap0_d;
      cap1_q    <= cap1_d;
      cnt_q     <= cnt_d;
      tally_q   <= tally_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign mic_clk_out      = mic_clk_q;
  assign pdm_tick_out     = tick_q;
  assign sample_out       = sample_q;
  assign sample_valid_out = valid_q;
  assign overrun_out      = overrun_q;

endmodule
